// File: rtl/binary_mul_13_1_uni_pkg.sv
// Shared constants and elaboration-time helpers for the 13x13 unsigned multiplier.
// W is the operand width, PW the full product width.
// The csa_* functions describe the shape of the 3:2 carry-save reduction tree.
package binary_mul_13_1_uni_pkg;

    localparam int W  = 13;
    localparam int PW = 2 * W;

    // Number of rows present at a given level of the reduction tree.
    // Each level compresses every complete group of three rows into two
    // (sum row + shifted carry row) and passes the leftover rows straight through.
    function automatic int csa_rows(input int w, input int lvl);
        int n;
        n = w;
        for (int k = 0; k < lvl; k++) begin
            n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

    // Number of compression levels needed to bring w rows down to two.
    function automatic int csa_levels(input int w);
        int n;
        int l;
        n = w;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + (n % 3);
            l++;
        end
        return l;
    endfunction

    // Index of the first row of a level in the flattened row store
    // (rows of all earlier levels are packed in front of it).
    function automatic int csa_base(input int w, input int lvl);
        int s;
        s = 0;
        for (int k = 0; k < lvl; k++) begin
            s += csa_rows(w, k);
        end
        return s;
    endfunction

endpackage

// File: rtl/mul_csa_fa.sv
// 1-bit full adder, the building block of the carry-save tree and the final adder.
// Ports: a, b, ci - addend bits and carry in; s - sum bit; co - carry out.
// Purely combinational, no state, no handshaking.
module mul_csa_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/binary_mul_13_1_uni.sv
// Unsigned WxW multiplier (partial products, carry-save tree, ripple CPA) with one output register.
// Ports: clk, rst_n (async active-low), en (capture enable), A/B operands, P registered product.
// Latency 1 cycle, throughput 1 pair/cycle; en=0 holds P and ignores A/B.
module binary_mul_13_1_uni
    import binary_mul_13_1_uni_pkg::*;
#(
    parameter int W = binary_mul_13_1_uni_pkg::W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [W-1:0]    A,
    input  logic [W-1:0]    B,
    output logic [2*W-1:0]  P
);

    localparam int PW     = 2 * W;
    localparam int NLVL   = csa_levels(W);
    localparam int NROWS  = csa_base(W, NLVL + 1);
    localparam int FBASE  = csa_base(W, NLVL);

    // Every row of every tree level lives in one flat vector, PW bits per row,
    // so each bit is driven exactly once and consumed exactly once.
    logic [NROWS*PW-1:0] rows;

    // ------------------------------------------------------------------
    // Partial products: row i = (A & {W{B[i]}}) << i
    // ------------------------------------------------------------------
    for (genvar i = 0; i < W; i++) begin : g_pp
        assign rows[i*PW +: PW] = {{W{1'b0}}, (A & {W{B[i]}})} << i;
    end

    // ------------------------------------------------------------------
    // Carry-save reduction tree.
    // All arithmetic is modulo 2^PW: the carry out of the top column is
    // discarded, which is exact because the true product always fits in PW bits.
    // ------------------------------------------------------------------
    for (genvar l = 0; l < NLVL; l++) begin : g_lvl
        localparam int N  = csa_rows(W, l);
        localparam int NG = N / 3;
        localparam int IB = csa_base(W, l);
        localparam int OB = csa_base(W, l + 1);

        for (genvar g = 0; g < NG; g++) begin : g_grp
            localparam int R0 = (IB + 3*g) * PW;
            localparam int R1 = R0 + PW;
            localparam int R2 = R1 + PW;
            localparam int S  = (OB + 2*g) * PW;
            localparam int C  = S + PW;

            // Carry row is the column carries shifted up by one.
            assign rows[C] = 1'b0;

            for (genvar b = 0; b < PW - 1; b++) begin : g_bit
                mul_csa_fa u_fa (
                    .a  (rows[R0 + b]),
                    .b  (rows[R1 + b]),
                    .ci (rows[R2 + b]),
                    .s  (rows[S + b]),
                    .co (rows[C + b + 1])
                );
            end

            // Top column: only the sum is kept.
            assign rows[S + PW - 1] = rows[R0 + PW - 1] ^ rows[R1 + PW - 1] ^ rows[R2 + PW - 1];
        end

        // Rows that do not complete a group of three pass to the next level unchanged.
        for (genvar k = 0; k < N % 3; k++) begin : g_pass
            assign rows[(OB + 2*NG + k)*PW +: PW] = rows[(IB + 3*NG + k)*PW +: PW];
        end
    end

    // ------------------------------------------------------------------
    // Final carry-propagate adder on the two remaining rows.
    // ------------------------------------------------------------------
    logic [PW-1:0] cpa_x;
    logic [PW-1:0] cpa_y;
    logic [PW-1:0] cpa_c;
    logic [PW-1:0] prod;

    assign cpa_x    = rows[FBASE*PW +: PW];
    assign cpa_y    = rows[(FBASE + 1)*PW +: PW];
    assign cpa_c[0] = 1'b0;

    for (genvar b = 0; b < PW - 1; b++) begin : g_cpa
        mul_csa_fa u_fa (
            .a  (cpa_x[b]),
            .b  (cpa_y[b]),
            .ci (cpa_c[b]),
            .s  (prod[b]),
            .co (cpa_c[b + 1])
        );
    end

    assign prod[PW-1] = cpa_x[PW-1] ^ cpa_y[PW-1] ^ cpa_c[PW-1];

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            P <= '0;
        end else if (en) begin
            P <= prod;
        end
    end

endmodule

// File: tb/tb_binary_mul_13_1_uni.sv
// Testbench for binary_mul_13_1_uni: directed vectors plus a random sweep
// with an asynchronous reset pulse in the middle.
module tb_binary_mul_13_1_uni;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [12:0] A;
    logic [12:0] B;
    logic [25:0] P;

    int checks = 0;
    int errors = 0;

    binary_mul_13_1_uni dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .A     (A),
        .B     (B),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
        end
    endtask

    // Drive a pair at the falling edge, then sample just after the rising edge.
    task automatic apply(input logic [12:0] a, input logic [12:0] b);
        @(negedge clk);
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    // Directed table: operands with hand-computed products.
    typedef struct {
        string       tag;
        logic [12:0] a;
        logic [12:0] b;
        logic [25:0] p;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{"max_x_max",   13'd8191, 13'd8191, 26'd67092481};
        vecs[1] = '{"max_x_zero",  13'd8191, 13'd0,    26'd0};
        vecs[2] = '{"zero_x_max",  13'd0,    13'd8191, 26'd0};
        vecs[3] = '{"one_x_max",   13'd1,    13'd8191, 26'd8191};
        vecs[4] = '{"pow2_x_pow2", 13'd4096, 13'd4096, 26'd16777216};
        vecs[5] = '{"carry_chain", 13'd4095, 13'd4097, 26'd16777215};
        vecs[6] = '{"mixed_a",     13'd1234, 13'd5678, 26'd7006652};
        vecs[7] = '{"alt_bits",    13'd5461, 13'd2730, 26'd14908530};

        // ---------------- reset ----------------
        rst_n = 1'b0;
        en    = 1'b1;
        A     = 13'd5;
        B     = 13'd7;
        #1;
        check("reset_initial", P, 26'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_held", P, 26'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_reset", P, 26'd35);

        // ---------------- latency ----------------
        @(negedge clk);
        A = 13'd123;
        B = 13'd456;
        #1;
        check("latency_before_edge", P, 26'd35);
        @(posedge clk);
        #1;
        check("latency_after_edge", P, 26'd56088);
        @(negedge clk);
        #1;
        check("latency_no_neg_change", P, 26'd56088);

        // ---------------- directed table ----------------
        foreach (vecs[i]) begin
            apply(vecs[i].a, vecs[i].b);
            check(vecs[i].tag, P, vecs[i].p);
        end

        // ---------------- enable hold ----------------
        apply(13'd10, 13'd20);
        check("en_capture", P, 26'd200);
        @(negedge clk);
        en = 1'b0;
        A  = 13'd300;
        B  = 13'd400;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("en_hold", P, 26'd200);
        end
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("en_resume", P, 26'd120000);

        // ---------------- random sweep with async reset pulse ----------------
        for (int i = 0; i < 2000; i++) begin
            logic [12:0] ra;
            logic [12:0] rb;
            int unsigned ex;
            ra = 13'($urandom_range(0, 8191));
            rb = 13'($urandom_range(0, 8191));
            ex = 32'(ra) * 32'(rb);
            apply(ra, rb);
            check("sweep", P, ex[25:0]);

            if (i == 1000) begin
                // Assert reset away from any edge: P must clear immediately.
                #2;
                rst_n = 1'b0;
                #1;
                check("async_reset_immediate", P, 26'd0);
                @(posedge clk);
                #1;
                check("async_reset_held", P, 26'd0);
                @(negedge clk);
                rst_n = 1'b1;
                A = 13'd77;
                B = 13'd99;
                #1;
                check("async_reset_release_no_edge", P, 26'd0);
                @(posedge clk);
                #1;
                check("async_reset_resume", P, 26'd7623);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
